// File: rtl/cpu_run_ctrl.sv
// Run control for the single-cycle CPU: clock-enable divider,
// debounced start/step buttons and run/pause/step/halt sequencing.
`timescale 1ns/1ps
module cpu_run_ctrl #(
  parameter int DIV_WIDTH       = 8,
  parameter int DEFAULT_DIV     = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RST_HOLD        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 step,
  input  logic                 mode,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 halt_req,
  output logic                 cpu_ce,
  output logic                 cpu_rst_n,
  output logic                 running,
  output logic [31:0]          cycle_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW  = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {
    S_RESET_HOLD,
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_STEP,
    S_HALTED
  } state_t;

  state_t state, state_n;

  logic [1:0]     btn;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     db;
  logic [1:0]     db_q;
  logic [1:0]     pulse;
  logic [DBW-1:0] db_cnt [2];
  logic           start_p;
  logic           step_p;

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 term;
  logic                 run_adv;
  logic                 tick;
  logic                 ce_next;
  logic [HW-1:0]        hold_cnt;

  assign btn     = {step, start};
  assign start_p = pulse[0];
  assign step_p  = pulse[1];

  // Any disagreement gap restarts the stability count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      pulse <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      db_q  <= db;
      pulse <= db & ~db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] ==
                     DBW'(DEBOUNCE_CYCLES - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_RESET_HOLD: begin
        if (hold_cnt == HW'(RST_HOLD - 1)) begin
          state_n = S_IDLE;
        end
      end
      S_IDLE: begin
        if (start_p) begin
          state_n = mode ? S_STEP : S_RUN;
        end
      end
      S_RUN, S_STEP: begin
        if (halt_req) begin
          state_n = S_HALTED;
        end else if (start_p) begin
          state_n = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start_p) begin
          state_n = S_RUN;
        end
      end
      S_HALTED: begin
        if (start_p) begin
          state_n = S_RESET_HOLD;
        end
      end
      default: state_n = S_RESET_HOLD;
    endcase
  end

  // The divider only advances on cycles that stay in RUN,
  // so a pause or halt never swallows a partial count.
  assign term    = (div_q <= DIV_WIDTH'(1)) ||
                   (div_cnt == div_q - DIV_WIDTH'(1));
  assign run_adv = (state == S_RUN) && (state_n == S_RUN);
  assign tick    = run_adv && term && !div_load;
  assign ce_next = tick ||
                   ((state == S_STEP) &&
                    (state_n == S_STEP) && step_p);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= DIV_WIDTH'(DEFAULT_DIV);
      div_cnt <= '0;
    end else if (div_load) begin
      div_q   <= div_value;
      div_cnt <= '0;
    end else if ((state == S_IDLE) &&
                 (state_n == S_RUN)) begin
      div_cnt <= '0;
    end else if (run_adv) begin
      div_cnt <= term ? '0 : div_cnt + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RESET_HOLD;
      hold_cnt    <= '0;
      cpu_ce      <= 1'b0;
      cpu_rst_n   <= 1'b0;
      running     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state     <= state_n;
      hold_cnt  <= ((state == S_RESET_HOLD) &&
                    (state_n == S_RESET_HOLD)) ?
                   hold_cnt + 1'b1 : '0;
      cpu_ce    <= ce_next;
      cpu_rst_n <= (state_n != S_RESET_HOLD);
      running   <= (state_n == S_RUN) ||
                   (state_n == S_STEP);
      if (state_n == S_RESET_HOLD) begin
        cycle_count <= '0;
      end else if (ce_next && (cycle_count != '1)) begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset, free-run, bounce,
// divider reload, halt, single-step and pause/resume.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        step;
  logic        mode;
  logic        div_load;
  logic [7:0]  div_value;
  logic        halt_req;
  logic        cpu_ce;
  logic        cpu_rst_n;
  logic        running;
  logic [31:0] cycle_count;

  int n_chk  = 0;
  int n_fail = 0;

  cpu_run_ctrl #(
    .DIV_WIDTH(8),
    .DEFAULT_DIV(4),
    .DEBOUNCE_CYCLES(16),
    .RST_HOLD(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .step(step),
    .mode(mode),
    .div_load(div_load),
    .div_value(div_value),
    .halt_req(halt_req),
    .cpu_ce(cpu_ce),
    .cpu_rst_n(cpu_rst_n),
    .running(running),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    step      = 1'b0;
    mode      = 1'b0;
    div_load  = 1'b0;
    div_value = 8'd0;
    halt_req  = 1'b0;
    repeat (3) tick();
    chk("rst_ce", 32'(cpu_ce), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_count", cycle_count, 32'd0);

    // Reset release: CPU reset held 4 cycles.
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_low", 32'(cpu_rst_n), 32'd0);
    end
    tick();
    chk("hold_rise", 32'(cpu_rst_n), 32'd1);

    // Clean start press: pulse after 19, RUN after 20.
    start = 1'b1;
    repeat (19) tick();
    chk("pre_run", 32'(running), 32'd0);
    tick();
    chk("run_entry", 32'(running), 32'd1);
    chk("run_entry_ce", 32'(cpu_ce), 32'd0);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("div4_ce", 32'(cpu_ce), 32'((i % 4) == 3));
    end
    chk("div4_count", cycle_count, 32'd10);

    // Reload on the terminal-count cycle.
    repeat (3) tick();
    div_load  = 1'b1;
    div_value = 8'd1;
    tick();
    chk("load1_no_ce", 32'(cpu_ce), 32'd0);
    div_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("div1_ce", 32'(cpu_ce), 32'd1);
    end
    div_load  = 1'b1;
    div_value = 8'd0;
    tick();
    chk("load0_no_ce", 32'(cpu_ce), 32'd0);
    div_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("div0_ce", 32'(cpu_ce), 32'd1);
    end
    chk("div_count", cycle_count, 32'd20);

    // Reset mid-RUN drops everything on the same edge.
    rst_n = 1'b0;
    tick();
    chk("midrst_ce", 32'(cpu_ce), 32'd0);
    chk("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_count", cycle_count, 32'd0);
    rst_n = 1'b1;

    // Bouncing start: no pulse until 19 after last edge.
    for (int i = 0; i < 60; i++) begin
      start = ((i / 5) % 2) == 0;
      tick();
      chk("bounce_idle", 32'(running), 32'd0);
    end
    start = 1'b1;
    repeat (19) tick();
    chk("bounce_pre", 32'(running), 32'd0);
    tick();
    chk("bounce_run", 32'(running), 32'd1);
    repeat (30) tick();
    chk("bounce_once", 32'(running), 32'd1);
    start = 1'b0;
    repeat (22) tick();

    // Halt and start in the same cycle: halt wins.
    start = 1'b1;
    repeat (19) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    start    = 1'b0;
    chk("halt_running", 32'(running), 32'd0);
    chk("halt_ce", 32'(cpu_ce), 32'd0);
    chk("halt_count", cycle_count, 32'd17);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("halted_ce", 32'(cpu_ce), 32'd0);
    end
    repeat (10) tick();
    start = 1'b1;
    repeat (19) tick();
    tick();
    start = 1'b0;
    chk("rehold_low", 32'(cpu_rst_n), 32'd0);
    chk("rehold_count", cycle_count, 32'd0);
    repeat (3) tick();
    chk("rehold_low3", 32'(cpu_rst_n), 32'd0);
    tick();
    chk("rehold_rise", 32'(cpu_rst_n), 32'd1);
    chk("rehold_idle", 32'(running), 32'd0);

    // Single-step mode: three presses, three pulses.
    mode = 1'b1;
    repeat (22) tick();
    start = 1'b1;
    repeat (20) tick();
    start = 1'b0;
    chk("step_entry", 32'(running), 32'd1);
    chk("step_entry_ce", 32'(cpu_ce), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      repeat (19) tick();
      chk("step_pre_ce", 32'(cpu_ce), 32'd0);
      tick();
      chk("step_ce", 32'(cpu_ce), 32'd1);
      tick();
      chk("step_post_ce", 32'(cpu_ce), 32'd0);
      step = 1'b0;
      repeat (22) tick();
      chk("step_running", 32'(running), 32'd1);
    end
    chk("step_count", cycle_count, 32'd3);

    // Pause at counter 2, then resume from it.
    rst_n = 1'b0;
    mode  = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    start = 1'b1;
    repeat (20) tick();
    start = 1'b0;
    chk("p_run", 32'(running), 32'd1);
    for (int k = 1; k <= 42; k++) begin
      if (k == 24) start = 1'b1;
      tick();
      chk("p_run_ce", 32'(cpu_ce), 32'((k % 4) == 0));
    end
    tick();
    start = 1'b0;
    chk("p_paused", 32'(running), 32'd0);
    chk("p_paused_ce", 32'(cpu_ce), 32'd0);
    chk("p_count", cycle_count, 32'd10);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("p_idle_ce", 32'(cpu_ce), 32'd0);
    end
    start = 1'b1;
    repeat (19) tick();
    tick();
    start = 1'b0;
    chk("p_resume", 32'(running), 32'd1);
    chk("p_resume_ce0", 32'(cpu_ce), 32'd0);
    tick();
    chk("p_resume_ce1", 32'(cpu_ce), 32'd0);
    tick();
    chk("p_resume_ce2", 32'(cpu_ce), 32'd1);
    chk("p_resume_count", cycle_count, 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Parametrised run-control and clock-enable generator for the single-cycle CPU. It replaces the fixed divide-by-4 ripple clock with a single `clk` domain and a programmable `cpu_ce` strobe. It also replaces the raw `start` level with synchronised, debounced start/step pulses and adds a run/pause/halt/single-step state machine. It sits in the top level between the HFOSC output and the CPU and memories, which advance only when `cpu_ce`=1.

Parameters:
DIV_WIDTH, 8, width of the divide-ratio register.
DEFAULT_DIV, 4, divide ratio loaded at reset; 0 and 1 both mean `cpu_ce` on every cycle.
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a button level is accepted (≥2).
RST_HOLD, 4, cycles `cpu_rst_n` is held low on entry to RESET_HOLD (≥1).

Ports:
clk  in  1  system clock (HFOSC output).
rst_n  in  1  synchronous active-low reset.
start  in  1  asynchronous start/pause button, active high.
step  in  1  asynchronous single-step button, active high.
mode  in  1  0 = free-run, 1 = single-step; sampled only in IDLE.
div_load  in  1  load `div_value` into the divide register.
div_value  in  DIV_WIDTH  new divide ratio.
halt_req  in  1  synchronous halt request from the CPU (e.g. ebreak), level.
cpu_ce  out  1  one-clk CPU/memory advance strobe, registered.
cpu_rst_n  out  1  CPU reset, active low, registered.
running  out  1  1 in RUN or STEP.
cycle_count  out  32  number of `cpu_ce` pulses since the last CPU reset.

Behaviour:
- Single clock domain; reset is synchronous and active-low. All state updates on posedge `clk`; `rst_n`=0 overrides everything in the same edge.
- Reset values:
  - `cpu_ce`=0, `cpu_rst_n`=0, `running`=0, `cycle_count`=0.
  - divide register = DEFAULT_DIV, divider counter = 0.
  - Debounced levels = 0, state = RESET_HOLD with hold counter = 0.
- Button path, identical for `start` and `step`:
  - 2-flop synchroniser.
  - Debounced level changes only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A rising edge of the debounced level gives a 1-cycle pulse (`start_p`, `step_p`), registered.
  - Latency from a clean input edge to the pulse is DEBOUNCE_CYCLES+3 cycles.
- Divider:
  - Counter runs 0..div-1 only in RUN and wraps to 0. `tick`=1 when counter==div-1, or every cycle if div≤1.
  - `div_load`=1 loads `div_value` and clears the counter. No `tick` that cycle, even if the counter was terminal; the load has priority.
- FSM:
  - RESET_HOLD: `cpu_rst_n`=0 for RST_HOLD cycles, `cycle_count` cleared, then → IDLE.
  - IDLE: `cpu_rst_n`=1, `cpu_ce`=0. On `start_p`: → STEP if `mode`=1, else → RUN with the divider counter cleared.
  - RUN: `cpu_ce` is registered `tick`, so it asserts one cycle after the terminal count.
    - `halt_req` → HALTED.
    - `start_p` → PAUSE.
    - If both arrive in the same cycle, HALTED wins.
  - PAUSE: `cpu_ce`=0 and the divider counter is frozen. `start_p` → RUN, resuming the count without clearing it. `halt_req` is ignored.
  - STEP: each `step_p` produces exactly one `cpu_ce` on the following cycle, independent of the divider. `halt_req` → HALTED; `start_p` → PAUSE.
  - HALTED: `cpu_ce`=0, `running`=0. `start_p` → RESET_HOLD, which re-resets the CPU and clears `cycle_count`. `step_p` is ignored.
- `halt_req` is only acted on in RUN/STEP. If `cpu_ce` was already registered on the cycle `halt_req` is seen, that pulse still completes; no further pulses follow.
- `cycle_count` increments on every `cpu_ce`=1 and saturates at 0xFFFFFFFF (no wrap).
- `running`=1 exactly when the state is RUN or STEP, registered with the state.
- `mode` changes outside IDLE have no effect.
- `rst_n` low mid-RUN: `cpu_ce` drops to 0 and `cpu_rst_n` to 0 on that edge; the FSM restarts in RESET_HOLD.

Test Plan:
- Reset release, DEFAULT_DIV=4, `mode`=0, clean start press → `cpu_rst_n` rises 4 cycles after `rst_n`. `start_p` at DEBOUNCE+3. `cpu_ce` then every 4th cycle; `cycle_count`=10 after 40 RUN cycles.
- `start` bounces 0/1 every 5 cycles for 60 cycles, then held high → exactly one `start_p`, 19 cycles after the last transition.
- In RUN at div=4, assert `div_load` with `div_value`=1 on the terminal-count cycle → no `cpu_ce` on the next cycle, then `cpu_ce` every cycle. `div_value`=0 behaves the same as 1.
- `mode`=1, start, then 3 step presses → exactly 3 `cpu_ce` pulses, each 1 cycle after its `step_p`. `cycle_count`=3 and `running`=1 throughout.
- RUN, `halt_req` and `start_p` in the same cycle → state HALTED, `running`=0, no further `cpu_ce`. The next start press → `cpu_rst_n` low for 4 cycles, `cycle_count`=0, then IDLE.
- RUN, start press to pause at counter=2, wait 50 cycles, press again → no `cpu_ce` while paused. The first `cpu_ce` comes 2 cycles after resume, since the count resumes from 2; `rst_n` pulse mid-RUN forces `cpu_ce`=0 and `cpu_rst_n`=0 on that edge.
